// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one 8x8 unsigned multiplier between NREQ requesters. When idle it
// picks a requester round-robin (search starts one past the last requester
// served). It then latches that requester's operands and pulses mul_en for
// one cycle. It waits for mul_ack, and returns mul_out to the winner with a
// one-cycle done pulse. Every output is a register.
//
// Optional feature macro: MUL_ARB_TIMEOUT_EN
//   Defined   : the WAIT state aborts after TIMEOUT cycles without mul_ack.
//               The abort pulses done and err together and returns result=0.
//   Undefined : WAIT waits indefinitely and err is tied low.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  WAIT cycles before abort (timeout build only)
//
// Ports
//   clk      clock, all logic on the rising edge
//   reset    asynchronous active-high reset
//   req      per-requester request level
//   req_a    operand a, requester i at [8i+7:8i]
//   req_b    operand b, same packing as req_a
//   gnt      one-hot owner of the multiplier (ISSUE..WAIT)
//   done     one-hot, one-cycle pulse when result is valid for requester i
//   result   product of the last completed operation, held until next done
//   err      one-cycle abort flag alongside done (timeout build only)
//   mul_a    operand a to the multiplier
//   mul_b    operand b to the multiplier
//   mul_en   one-cycle start strobe to the multiplier
//   mul_out  product from the multiplier
//   mul_ack  completion strobe from the multiplier
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [15:0]       result,
    output logic              err,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    output logic              mul_en,
    input  logic [15:0]       mul_out,
    input  logic              mul_ack
);

    localparam int            PW   = $clog2(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    // Elaborates to nothing for a legal configuration. It records the
    // supported parameter range in one place.
    generate
        if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_out_of_range
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next;      // last requester served
    logic [PW-1:0]   owner, owner_next;  // index of the current grant
    logic [NREQ-1:0] gnt_next;
    logic [NREQ-1:0] done_next;
    logic [15:0]     result_next;
    logic [7:0]      mul_a_next;
    logic [7:0]      mul_b_next;
    logic            mul_en_next;
    logic            expire;             // WAIT gave up on mul_ack this cycle

    // -------------------------------------------------------------------------
    // Round-robin search. The walk starts one past ptr and visits every index
    // once, wrapping at NREQ-1. This holds even when NREQ is not a power of two.
    // -------------------------------------------------------------------------
    logic          win_found;
    logic [PW-1:0] win_idx;

    always_comb begin
        logic [PW-1:0] cand;
        cand      = ptr;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == LAST) ? '0 : cand + 1'b1;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional WAIT timeout. The counter is held at zero outside WAIT, so it
    // starts from zero on every entry to WAIT. An ack in the final cycle wins
    // over the abort.
    // -------------------------------------------------------------------------
`ifdef MUL_ARB_TIMEOUT_EN
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    assign expire = (state == WAIT) && !mul_ack && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= expire;
            if (state != WAIT) begin
                cnt <= '0;
            end else if (!mul_ack && !expire) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together from values computed before the edge, whatever the
    // order in which the simulator evaluates the processes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= LAST;   // requester 0 wins the first arbitration
            owner  <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            mul_en <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            owner  <= owner_next;
            gnt    <= gnt_next;
            done   <= done_next;
            result <= result_next;
            mul_a  <= mul_a_next;
            mul_b  <= mul_b_next;
            mul_en <= mul_en_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal is assigned a default before the case statement, so
    // no path leaves a value unassigned and no latch can be inferred. Registered
    // values hold by default. The pulses done and mul_en default to low.
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        owner_next  = owner;
        gnt_next    = gnt;
        done_next   = '0;
        result_next = result;
        mul_a_next  = mul_a;
        mul_b_next  = mul_b;
        mul_en_next = 1'b0;

        case (state)
            IDLE: begin
                gnt_next = '0;
                if (win_found) begin
                    // Operands are captured only here. Later changes on
                    // req_a/req_b cannot disturb the operation in flight.
                    mul_a_next        = req_a[{win_idx, 3'b000} +: 8];
                    mul_b_next        = req_b[{win_idx, 3'b000} +: 8];
                    gnt_next[win_idx] = 1'b1;
                    owner_next        = win_idx;
                    mul_en_next       = 1'b1;
                    state_next        = ISSUE;
                end
            end

            ISSUE: begin
                // mul_en drops by default after its single cycle.
                state_next = WAIT;
            end

            WAIT: begin
                // Completion does not depend on req. A requester that has
                // dropped its request still gets its done pulse.
                if (mul_ack || expire) begin
                    result_next = expire ? 16'd0 : mul_out;
                    done_next   = gnt;
                    ptr_next    = owner;
                    gnt_next    = '0;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

endmodule
